dmem_rv32: RTL and testbench

- Parametrised, byte-addressed RV32I data memory. Next generation of the fixed 512x32 word RAM.
- Adds configurable depth, byte/halfword/word stores via byte strobes, and sign/zero-extended loads selected by funct3.
- Registered read, request/response valid handshake, access-error flag.
- Sits between the core's load/store stage and local SRAM.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_load_align.sv | 41 ++++
 rtl/dmem_rv32.sv | 106 ++++++++++
 tb/tb_dmem_rv32.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_rv32 data memory: funct3 encodings,
// lane count and access-legality helpers.
package dmem_pkg;

  localparam int LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_H, F3_HU: is_misaligned = lane[0];
      F3_W:        is_misaligned = (lane != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load path: selects the addressed byte/half of a word,
// moves it to bit 0 and sign- or zero-extends it according to funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  // Halfwords only look at lane[1]; the low bit is ignored or rejected upstream.
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    rdata = 32'h0;
    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      F3_W:    rdata = word;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_rv32.sv
// Byte-addressed RV32I data memory with byte-strobed stores, extended loads,
// one-cycle registered response and store counter.
// Optional build macro: DMEM_MISALIGN_CHECK_EN rejects misaligned H/HU/W accesses.
module dmem_rv32
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] RST_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       store_cnt
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [LANES-1:0][7:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane;
  logic                  err;
  logic                  do_store;
  logic [LANES-1:0]      strb;
  logic [LANES-1:0][7:0] wdata_rep;
  logic [31:0]           rd_word;
  logic [31:0]           load_data;

  assign idx  = req_addr[ADDR_W-1:2];
  assign lane = req_addr[1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign err = ~f3_legal(req_funct3, req_we) | is_misaligned(req_funct3, lane);
`else
  assign err = ~f3_legal(req_funct3, req_we);
`endif

  assign do_store = req_valid & req_we & ~err;

  // Store data is replicated across lanes so the strobes alone pick the target bytes.
  always_comb begin
    strb      = '0;
    wdata_rep = req_wdata;
    case (req_funct3)
      F3_B: begin
        strb      = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        strb      = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        strb      = 4'b1111;
        wdata_rep = req_wdata;
      end
      default: begin
        strb      = '0;
        wdata_rep = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int l = 0; l < LANES; l++) begin
        if (strb[l]) mem[idx][l] <= wdata_rep[l];
      end
    end
  end

  assign rd_word = mem[idx];

  dmem_load_align u_align (
    .word   (rd_word),
    .lane   (lane),
    .funct3 (req_funct3),
    .rdata  (load_data)
  );

  // Response data and error hold their last values across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= RST_RDATA;
      store_cnt <= 16'h0;
    end else begin
      rsp_valid <= req_valid;
      if (req_valid) begin
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? 32'h0 : load_data;
      end
      if (do_store) store_cnt <= store_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_rv32.sv
// Directed self-checking bench for dmem_rv32 with hand-computed expectations.
module tb_dmem_rv32;

  localparam int          ADDR_W    = 11;
  localparam logic [31:0] RST_RDATA = 32'hA5A5_5A5A;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [15:0]       store_cnt;

  int total_checks;
  int bad_checks;
  logic [15:0] exp_cnt;

  dmem_rv32 #(.ADDR_W(ADDR_W), .RST_RDATA(RST_RDATA)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .store_cnt  (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drives one request for one cycle; returns #1 after the edge that answers it.
  task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                               input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic [31:0] rdata, input logic err);
    checkOutput({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
    checkOutput({tag, "_rdata"}, rsp_rdata, rdata);
    checkOutput({tag, "_err"},   {31'h0, rsp_err}, {31'h0, err});
    checkOutput({tag, "_cnt"},   {16'h0, store_cnt}, {16'h0, exp_cnt});
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    exp_cnt      = 16'h0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = '0;
    req_wdata    = 32'h0;

    #12;
    checkOutput("rst_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_err",   {31'h0, rsp_err}, 32'h0);
    checkOutput("rst_rdata", rsp_rdata, RST_RDATA);
    checkOutput("rst_cnt",   {16'h0, store_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word store and load at the top of memory
    applyStimulus(1, 1, 3'b010, 11'h7FC, 32'hDEADBEEF); exp_cnt++;
    checkRsp("sw_7fc", 32'h0, 1'b0);
    applyStimulus(1, 0, 3'b010, 11'h7FC, 32'h0);
    checkRsp("lw_7fc", 32'hDEADBEEF, 1'b0);

    applyStimulus(0, 0, 3'b010, 11'h0, 32'h0);
    checkOutput("idle_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("idle_hold",  rsp_rdata, 32'hDEADBEEF);

    // Byte lanes
    applyStimulus(1, 1, 3'b010, 11'h010, 32'h0); exp_cnt++;
    checkRsp("sw_10", 32'h0, 1'b0);
    applyStimulus(1, 1, 3'b000, 11'h011, 32'h1234_5680); exp_cnt++;
    checkRsp("sb_11", 32'h0, 1'b0);
    applyStimulus(1, 0, 3'b000, 11'h011, 32'h0);
    checkRsp("lb_11", 32'hFFFFFF80, 1'b0);
    applyStimulus(1, 0, 3'b100, 11'h011, 32'h0);
    checkRsp("lbu_11", 32'h00000080, 1'b0);
    applyStimulus(1, 0, 3'b010, 11'h010, 32'h0);
    checkRsp("lw_10", 32'h00008000, 1'b0);

    // Halfwords
    applyStimulus(1, 1, 3'b010, 11'h020, 32'h11223344); exp_cnt++;
    checkRsp("sw_20", 32'h0, 1'b0);
    applyStimulus(1, 1, 3'b001, 11'h022, 32'hABCD_8001); exp_cnt++;
    checkRsp("sh_22", 32'h0, 1'b0);
    applyStimulus(1, 0, 3'b001, 11'h022, 32'h0);
    checkRsp("lh_22", 32'hFFFF8001, 1'b0);
    applyStimulus(1, 0, 3'b101, 11'h022, 32'h0);
    checkRsp("lhu_22", 32'h00008001, 1'b0);
    applyStimulus(1, 0, 3'b101, 11'h020, 32'h0);
    checkRsp("lhu_20", 32'h00003344, 1'b0);
    applyStimulus(1, 0, 3'b010, 11'h020, 32'h0);
    checkRsp("lw_20", 32'h80013344, 1'b0);

    // Illegal funct3
    applyStimulus(1, 0, 3'b011, 11'h020, 32'h0);
    checkRsp("ld_f3_011", 32'h0, 1'b1);
    applyStimulus(1, 1, 3'b100, 11'h010, 32'hFFFFFFFF);
    checkRsp("st_f3_100", 32'h0, 1'b1);
    applyStimulus(1, 0, 3'b010, 11'h010, 32'h0);
    checkRsp("lw_10_kept", 32'h00008000, 1'b0);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_CHECK_EN
    applyStimulus(1, 1, 3'b010, 11'h013, 32'hCAFEF00D);
    checkRsp("sw_13", 32'h0, 1'b1);
    applyStimulus(1, 0, 3'b010, 11'h010, 32'h0);
    checkRsp("lw_10_after", 32'h00008000, 1'b0);
    applyStimulus(1, 0, 3'b001, 11'h023, 32'h0);
    checkRsp("lh_23", 32'h0, 1'b1);
`else
    applyStimulus(1, 1, 3'b010, 11'h013, 32'hCAFEF00D); exp_cnt++;
    checkRsp("sw_13", 32'h0, 1'b0);
    applyStimulus(1, 0, 3'b010, 11'h010, 32'h0);
    checkRsp("lw_10_after", 32'hCAFEF00D, 1'b0);
    applyStimulus(1, 0, 3'b001, 11'h023, 32'h0);
    checkRsp("lh_23", 32'hFFFF8001, 1'b0);
`endif

    // Reset mid-cycle with a valid response pending
    applyStimulus(1, 0, 3'b010, 11'h7FC, 32'h0);
    checkRsp("lw_pre_rst", 32'hDEADBEEF, 1'b0);
    req_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("mid_rst_err",   {31'h0, rsp_err}, 32'h0);
    checkOutput("mid_rst_rdata", rsp_rdata, RST_RDATA);
    checkOutput("mid_rst_cnt",   {16'h0, store_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0;

    applyStimulus(1, 0, 3'b010, 11'h7FC, 32'h0);
    checkRsp("lw_mem_kept", 32'hDEADBEEF, 1'b0);

    // Counter wrap
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(1, 1, 3'b010, 11'h100, i);
    end
    exp_cnt = 16'hFFFF;
    checkRsp("cnt_ffff", 32'h0, 1'b0);
    applyStimulus(1, 1, 3'b010, 11'h100, 32'h5555AAAA);
    exp_cnt = 16'h0000;
    checkRsp("cnt_wrap", 32'h0, 1'b0);
    applyStimulus(1, 0, 3'b010, 11'h100, 32'h0);
    checkRsp("lw_100", 32'h5555AAAA, 1'b0);

    applyStimulus(0, 0, 3'b010, 11'h0, 32'h0);
    checkOutput("idle2_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("idle2_hold",  rsp_rdata, 32'h5555AAAA);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
